// File: rtl/g2b_seq_conv_pkg.sv
// -----------------------------------------------------------------------------
// g2b_pkg
// Shared types and constants for the bit-serial Gray-to-binary decoder.
//   state_t    : controller states (IDLE, CONV, DONE) on a 2-bit encoding
//   G2B_W_DEF  : default word width
// -----------------------------------------------------------------------------
package g2b_pkg;

  localparam int G2B_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : g2b_pkg

// File: rtl/g2b_seq_conv_if.sv
// -----------------------------------------------------------------------------
// g2b_seq_conv_if
// Handshake bundle for g2b_seq_conv. Index 0 is the MSB on both word fields.
//   in_valid / in_ready / g       : Gray word input handshake
//   out_valid / out_ready / b     : binary result output handshake
//   busy                          : decoder is not in IDLE
// Modports:
//   master : the side that supplies Gray words and consumes results
//   slave  : the decoder itself
// -----------------------------------------------------------------------------
interface g2b_seq_conv_if
  import g2b_pkg::*;
#(
  parameter int W = G2B_W_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [0:W-1] g;
  logic         out_valid;
  logic         out_ready;
  logic [0:W-1] b;
  logic         busy;

  modport master (
    output in_valid, g, out_ready,
    input  in_ready, out_valid, b, busy
  );

  modport slave (
    input  in_valid, g, out_ready,
    output in_ready, out_valid, b, busy
  );

endinterface : g2b_seq_conv_if

// File: rtl/g2b_seq_conv.sv
// -----------------------------------------------------------------------------
// g2b_seq_conv
// Bit-serial Gray-to-binary decoder. A W-bit Gray word is accepted on the
// input handshake, then one binary bit is resolved per clock, MSB first,
// through a running XOR (carry) of the Gray bits seen so far. The finished
// word is presented on the output handshake.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : g2b_seq_conv_if.slave (in_valid/in_ready/g, out_valid/out_ready/b,
//            busy)
//
// Timing: acceptance edge e0, bits resolve on e1..eW, out_valid high after eW.
// All outputs come from registers or the state register only.
// -----------------------------------------------------------------------------
module g2b_seq_conv
  import g2b_pkg::*;
#(
  parameter int W  = G2B_W_DEF,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  g2b_seq_conv_if.slave bus
);

  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  state_t        r_state;
  logic [0:W-1]  r_greg;
  logic [CW-1:0] r_idx;
  logic          r_carry;
  logic [0:W-1]  r_b;
  logic          r_in_ready;
  logic          r_out_valid;

  // Next binary bit: running XOR of all Gray bits up to and including r_idx.
  wire logic w_bit = r_carry ^ r_greg[r_idx];

  // Counter codes above W-1 can only exist when W is not a power of two and
  // are never reached in normal operation; they are flushed back to IDLE.
  wire logic w_idx_bad = (int'(r_idx) >= W);

  // NOTE: every register below is updated with non-blocking assignments so
  // all state advances together on the clock edge, regardless of statement
  // order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_greg      <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_b         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_greg     <= bus.g;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= CONV;
          end
        end

        CONV: begin
          if (w_idx_bad) begin
            r_idx      <= '0;
            r_in_ready <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_b[r_idx] <= w_bit;
            r_carry    <= w_bit;
            if (r_idx == LAST_IDX) begin
              // Hold the index at W-1 rather than wrapping.
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        DONE: begin
          // r_b is not written here, so the result stays stable under
          // backpressure.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.b         = r_b;
  assign bus.busy      = (r_state != IDLE);

endmodule : g2b_seq_conv

// File: tb/tb_g2b_seq_conv.sv
// -----------------------------------------------------------------------------
// tb_g2b_seq_conv
// Self-checking bench for g2b_seq_conv at W=4 and W=8. Inputs are driven and
// outputs sampled on the falling clock edge. Expected results come from a
// hand-written vector table and from a reference model that inverts the
// binary-to-Gray mapping by search.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_g2b_seq_conv;
  import g2b_pkg::*;

  localparam int CLK_NS = 10;

  logic clk;
  logic rst_n;

  g2b_seq_conv_if #(.W(4)) bus4 ();
  g2b_seq_conv_if #(.W(8)) bus8 ();

  g2b_seq_conv #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  g2b_seq_conv #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;
  time last_acc = 0;

  typedef struct {
    int         w;
    logic [7:0] g;
    logic [7:0] b;
    int         hold;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the binary value whose Gray code equals g.
  function automatic logic [7:0] ref_bin(input int w, input logic [7:0] gw);
    for (int v = 0; v < (1 << w); v++) begin
      if (((v ^ (v >> 1)) & 8'hFF) == int'(gw)) return 8'(v);
    end
    return 8'hXX;
  endfunction

  function automatic logic [7:0] gray_of(input int v);
    return 8'(v ^ (v >> 1));
  endfunction

  task automatic set_in(input int w, input logic v, input logic [7:0] gw);
    if (w == 8) begin
      bus8.in_valid = v;
      bus8.g        = gw;
    end else begin
      bus4.in_valid = v;
      bus4.g        = gw[3:0];
    end
  endtask

  task automatic set_ordy(input int w, input logic r);
    if (w == 8) bus8.out_ready = r;
    else        bus4.out_ready = r;
  endtask

  function automatic logic ov_of(input int w);
    return (w == 8) ? bus8.out_valid : bus4.out_valid;
  endfunction

  function automatic logic ir_of(input int w);
    return (w == 8) ? bus8.in_ready : bus4.in_ready;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 8) ? bus8.busy : bus4.busy;
  endfunction

  function automatic logic [7:0] b_of(input int w);
    return (w == 8) ? bus8.b : {4'b0, bus4.b};
  endfunction

  // Sends one word, starting and ending at a falling edge with the DUT idle.
  // hold: cycles of out_ready=0 in DONE; inj: offer another word during hold.
  task automatic send(input int w, input logic [7:0] gw, input int hold,
                      input bit chk_gap, input bit inj, output logic [7:0] bres);
    int  n;
    time t_acc;
    set_in(w, 1'b1, gw);
    set_ordy(w, hold == 0);
    check("in_ready_idle", 64'(ir_of(w)), 64'd1);
    @(posedge clk);
    t_acc = $time;
    if (chk_gap) check("throughput_cycles", 64'((t_acc - last_acc) / CLK_NS), 64'(w + 2));
    last_acc = t_acc;
    @(negedge clk);
    set_in(w, 1'b0, 8'($urandom));
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ov_of(w) || n > 3 * w + 4) break;
    end
    check("latency", 64'(n), 64'(w));
    bres = b_of(w);
    if (inj) set_in(w, 1'b1, 8'h01);
    for (int i = 0; i < hold; i++) begin
      check("hold_ov_b", {55'd0, ov_of(w), b_of(w)}, {55'd0, 1'b1, bres});
      if (inj) check("hold_in_ready", 64'(ir_of(w)), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    set_in(w, 1'b0, 8'h00);
    set_ordy(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("post_hs_ov_ir_busy", {ov_of(w), ir_of(w), busy_of(w)}, 64'b010);
  endtask

  initial begin
    #(CLK_NS * 20000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] res;
    int         seen;

    // Hand-computed vectors: b[i] = XOR of g[0..i], MSB first.
    vecs.push_back('{4, 8'b0110,     8'b0100,     0});
    vecs.push_back('{4, 8'b1000,     8'b1111,     0});
    vecs.push_back('{4, 8'b1111,     8'b1010,     2});
    vecs.push_back('{4, 8'b0001,     8'b0001,     0});
    vecs.push_back('{4, 8'b0101,     8'b0110,     1});
    vecs.push_back('{4, 8'b1010,     8'b1100,     0});
    vecs.push_back('{8, 8'b10000000, 8'b11111111, 0});
    vecs.push_back('{8, 8'b01010101, 8'b01100110, 0});
    vecs.push_back('{8, 8'b11111111, 8'b10101010, 3});

    // 1. Reset with random activity on the inputs.
    rst_n = 1'b0;
    bus4.out_ready = 1'b0;
    bus8.out_ready = 1'b0;
    set_in(8, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      set_in(4, 1'($urandom), 8'($urandom));
      @(negedge clk);
      check("rst_ir_ov_busy", {bus4.in_ready, bus4.out_valid, bus4.busy}, 64'b100);
      check("rst_b", 64'(bus4.b), 64'd0);
    end
    set_in(4, 1'b0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // 2. Table-driven vectors.
    foreach (vecs[i]) begin
      send(vecs[i].w, vecs[i].g, vecs[i].hold, 1'b0, 1'b0, res);
      check($sformatf("tbl_b_%0d", i), 64'(res), 64'(vecs[i].b));
    end

    // 3. Backpressure with a competing input word.
    send(4, 8'b1101, 5, 1'b0, 1'b1, res);
    check("bp_b", 64'(res), 64'b1001);
    check("bp_b_held_idle", 64'(b_of(4)), 64'b1001);

    // 4. Asynchronous reset after two CONV edges.
    set_in(4, 1'b1, 8'b1111);
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ir_ov_busy", {bus4.in_ready, bus4.out_valid, bus4.busy}, 64'b100);
    check("midrst_b", 64'(bus4.b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus4.out_valid) seen++;
    end
    check("midrst_no_ov", 64'(seen), 64'd0);
    send(4, 8'b0011, 0, 1'b0, 1'b0, res);
    check("midrst_next_b", 64'(res), 64'b0010);

    // 5. Exhaustive round trip through the binary-to-Gray mapping.
    for (int v = 0; v < 16; v++) begin
      send(4, gray_of(v), 0, v > 0, 1'b0, res);
      check($sformatf("rt_%0d", v), 64'(res), 64'(v));
    end

    // 6. Random words on both widths against the reference model.
    for (int i = 0; i < 40; i++) begin
      int         w;
      logic [7:0] gw;
      w  = ($urandom % 2) ? 8 : 4;
      gw = (w == 8) ? 8'($urandom) : 8'($urandom % 16);
      send(w, gw, int'($urandom_range(0, 3)), 1'b0, 1'b0, res);
      check("rand_b", 64'(res), 64'(ref_bin(w, gw)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_g2b_seq_conv
